// File: rtl/pio_pkg.sv
// Shared definitions for the PIO TX/RX FIFO pair: flag bit positions and
// the join-mode encoding plus its decode from the two join controls.
package pio_pkg;

  // Bit positions inside the sticky flag vector.
  localparam int FLAG_TXSTALL = 0;
  localparam int FLAG_TXOVER  = 1;
  localparam int FLAG_RXUNDER = 2;
  localparam int FLAG_RXSTALL = 3;

  typedef enum logic [1:0] {
    JOIN_NONE = 2'd0,
    JOIN_TX   = 2'd1,
    JOIN_RX   = 2'd2
  } join_mode_e;

  // Both joins requested at once cancel out and behave as unjoined.
  function automatic join_mode_e join_decode(input logic join_tx, input logic join_rx);
    if (join_tx && !join_rx) return JOIN_TX;
    if (join_rx && !join_tx) return JOIN_RX;
    return JOIN_NONE;
  endfunction

endpackage

// File: rtl/pio_fifo_if.sv
// Machine/host handshake bundle around the FIFO pair. The master side is
// the state machine plus host bus; the slave side is the FIFO block.
interface pio_fifo_if #(
  parameter int WIDTH = 32
);
  logic             mach_pull;
  logic [WIDTH-1:0] mach_din;
  logic             mach_empty;
  logic             mach_push;
  logic [WIDTH-1:0] mach_dout;
  logic             mach_full;
  logic             host_tx_wr;
  logic [WIDTH-1:0] host_tx_data;
  logic             host_tx_full;
  logic             host_rx_rd;
  logic [WIDTH-1:0] host_rx_data;
  logic             host_rx_empty;

  modport master (
    output mach_pull, mach_push, mach_dout, host_tx_wr, host_tx_data, host_rx_rd,
    input  mach_din, mach_empty, mach_full, host_tx_full, host_rx_data, host_rx_empty
  );

  modport slave (
    input  mach_pull, mach_push, mach_dout, host_tx_wr, host_tx_data, host_rx_rd,
    output mach_din, mach_empty, mach_full, host_tx_full, host_rx_data, host_rx_empty
  );
endinterface

// File: rtl/pio_fifo_buf.sv
// One circular FIFO with 2*DEPTH entries of storage whose usable capacity
// is chosen at run time (0, DEPTH or 2*DEPTH). Callers only strobe wr/rd
// when the operation is legal; the buffer does no qualification itself.
module pio_fifo_buf #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 32,
  localparam int AW    = $clog2(2*DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [LW-1:0]    cap,
  input  logic             flush,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [2*DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;

  // Pointers wrap at the current capacity rather than at the storage size.
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p, input logic [LW-1:0] c);
    return ({1'b0, p} + LW'(1) == c) ? '0 : p + AW'(1);
  endfunction

  // Pointer and occupancy state; flush empties the FIFO without touching storage.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= next_ptr(wr_ptr, cap);
      if (rd) rd_ptr <= next_ptr(rd_ptr, cap);
      count <= count + LW'(wr) - LW'(rd);
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; stale words are unreachable because count gates every read.
    if (wr) mem[wr_ptr] <= wdata;
  end

  // Status and show-ahead head word, derived only from registered state.
  always_comb begin
    empty = (count == '0);
    full  = (count == cap);
    level = count;
    rdata = empty ? '0 : mem[rd_ptr];
  end

endmodule

// File: rtl/pio_fifo.sv
// TX/RX FIFO pair between the host bus and one PIO state machine: join-mode
// decode, flush on join change, strobe qualification and sticky error flags.
module pio_fifo
  import pio_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 32,
  localparam int LW    = $clog2(2*DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          join_tx,
  input  logic          join_rx,
  pio_fifo_if.slave     bus,
  output logic [LW-1:0] tx_level,
  output logic [LW-1:0] rx_level,
  output logic [3:0]    flags,
  input  logic [3:0]    flag_clr
);

  join_mode_e       join_q;
  join_mode_e       join_eff;
  logic             flush;
  logic [LW-1:0]    tx_cap;
  logic [LW-1:0]    rx_cap;
  logic             tx_empty, tx_full, rx_empty, rx_full;
  logic             tx_wr, tx_rd, rx_wr, rx_rd;
  logic [WIDTH-1:0] tx_rdata, rx_rdata;
  logic [3:0]       flag_set;
  logic [3:0]       flags_q;

  // Join decode: a change against the latched mode flushes both FIFOs this cycle.
  always_comb begin
    join_eff = join_decode(join_tx, join_rx);
    flush    = (join_eff != join_q);
  end

  // Latched join mode and sticky flags; a new event wins over a clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      join_q  <= JOIN_NONE;
      flags_q <= '0;
    end else begin
      join_q  <= join_eff;
      flags_q <= (flags_q & ~flag_clr) | flag_set;
    end
  end

  // Per-direction capacity from the latched join mode.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    tx_cap = LW'(DEPTH);
    rx_cap = LW'(DEPTH);
    case (join_q)
      JOIN_TX: begin
        tx_cap = LW'(2*DEPTH);
        rx_cap = '0;
      end
      JOIN_RX: begin
        tx_cap = '0;
        rx_cap = LW'(2*DEPTH);
      end
      default: ;
    endcase
  end

  // Strobe qualification and error events; everything is discarded while flushing.
  always_comb begin
    tx_wr    = !flush && bus.host_tx_wr && !tx_full;
    tx_rd    = !flush && bus.mach_pull  && !tx_empty;
    rx_wr    = !flush && bus.mach_push  && !rx_full;
    rx_rd    = !flush && bus.host_rx_rd && !rx_empty;
    flag_set = '0;
    flag_set[FLAG_TXSTALL] = !flush && bus.mach_pull  && tx_empty;
    flag_set[FLAG_TXOVER]  = !flush && bus.host_tx_wr && tx_full;
    flag_set[FLAG_RXUNDER] = !flush && bus.host_rx_rd && rx_empty;
    flag_set[FLAG_RXSTALL] = !flush && bus.mach_push  && rx_full;
  end

  pio_fifo_buf #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_tx (
    .clk   (clk),
    .reset (reset),
    .cap   (tx_cap),
    .flush (flush),
    .wr    (tx_wr),
    .wdata (bus.host_tx_data),
    .rd    (tx_rd),
    .rdata (tx_rdata),
    .empty (tx_empty),
    .full  (tx_full),
    .level (tx_level)
  );

  pio_fifo_buf #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_rx (
    .clk   (clk),
    .reset (reset),
    .cap   (rx_cap),
    .flush (flush),
    .wr    (rx_wr),
    .wdata (bus.mach_dout),
    .rd    (rx_rd),
    .rdata (rx_rdata),
    .empty (rx_empty),
    .full  (rx_full),
    .level (rx_level)
  );

  // Drive the handshake outputs from the buffer status.
  always_comb begin
    bus.mach_din      = tx_rdata;
    bus.mach_empty    = tx_empty;
    bus.host_tx_full  = tx_full;
    bus.host_rx_data  = rx_rdata;
    bus.host_rx_empty = rx_empty;
    bus.mach_full     = rx_full;
    flags             = flags_q;
  end

endmodule

// File: doc/pio_fifo.md
# pio_fifo

Paired TX/RX FIFOs sitting between the host bus and one PIO state machine. The host writes the TX FIFO and the machine pulls from it (OUT/PULL, autopull). The machine pushes into the RX FIFO (IN/PUSH, autopush) and the host reads from it. The block supplies the machine's `din`/`empty`/`full` inputs, consumes its `pull`/`push`/`dout` strobes, supports joining both directions into one double-depth FIFO, and keeps sticky error flags for the host.

## Interface
Parameters:
- `DEPTH`, default 4: per-direction depth when unjoined. Must be a power of two.
- `WIDTH`, default 32: data width.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `join_tx` in 1: TX uses 2*DEPTH entries; RX is disabled.
- `join_rx` in 1: RX uses 2*DEPTH entries; TX is disabled.
- `mach_pull` in 1: machine pull strobe (combinational from the machine).
- `mach_din` out WIDTH: TX head word, show-ahead.
- `mach_empty` out 1: TX empty.
- `mach_push` in 1: machine push strobe.
- `mach_dout` in WIDTH: word the machine is pushing.
- `mach_full` out 1: RX full.
- `host_tx_wr` in 1: host write strobe.
- `host_tx_data` in WIDTH: host write data.
- `host_tx_full` out 1: TX full.
- `host_rx_rd` in 1: host read strobe.
- `host_rx_data` out WIDTH: RX head word, show-ahead.
- `host_rx_empty` out 1: RX empty.
- `tx_level` out $clog2(2*DEPTH)+1: TX occupancy.
- `rx_level` out $clog2(2*DEPTH)+1: RX occupancy.
- `flags` out 4: sticky flags {rxstall, rxunder, txover, txstall} (bits 3..0).
- `flag_clr` in 4: write-1-to-clear, same bit order as `flags`.

## Operation
- **Capacity per direction:**
  - Unjoined: DEPTH.
  - Joined toward that direction: 2*DEPTH.
  - Disabled by the other direction's join: 0.
  - `join_tx && join_rx` behaves as unjoined.
- **Disabled direction:** reports empty=1 and full=1, and accepts no operation.
- **Accept/pop rules:**
  - Pop TX when `mach_pull && !mach_empty`.
  - Accept host write when `host_tx_wr && !host_tx_full`.
  - RX is symmetric: push accepted when `mach_push && !mach_full`; pop when `host_rx_rd && !host_rx_empty`.
- **Rejected operations:** no state change except the flag.
  - `mach_pull` while empty sets txstall. This is normal for a blocking pull, which re-strobes on later enabled cycles.
  - `host_tx_wr` while full sets txover.
  - `host_rx_rd` while empty sets rxunder.
  - `mach_push` while full sets rxstall.
- **Flags:** set-on-event, cleared by the matching `flag_clr` bit. Set wins over a clear in the same cycle.
- **Head outputs:** `mach_din` and `host_rx_data` are forced to 0 while the respective FIFO is empty.
- **Pointers and levels:** circular pointers wrap modulo the current capacity. Level = writes minus pops, range 0..capacity.
- **Join change:** any change of the effective join mode flushes both FIFOs the following cycle (levels and pointers to 0). Flags are preserved. Operations in the flush cycle are discarded and set no flags.

## Timing
- **Reset values:**
  - levels 0; empty outputs 1; full outputs 0;
  - data outputs 0; flags 0;
  - join state latched as unjoined.
- **Latency:** all status and data outputs are registered-state derived, with no combinational path from strobe inputs to outputs.
  - A host write becomes visible on `mach_din`/`!mach_empty` the next cycle.
  - A machine push becomes visible on `host_rx_data` the next cycle.
- **Simultaneous push and pop on the same FIFO:**
  - Non-empty and non-full: both occur, level unchanged, head advances.
  - Empty: only the push occurs; the pop is rejected and its flag is set.
  - Full: only the pop occurs; the push is rejected and its flag is set.
- **Pop width:** at most one pop and one push per FIFO per cycle.
- **Flag timing:** flags update the cycle after the event.
- **Reset mid-operation:** contents are discarded; strobes in the reset cycle are ignored.

## Structure
- **Package `pio_pkg`:**
  - flag bit indices: `FLAG_TXSTALL`=0, `FLAG_TXOVER`=1, `FLAG_RXUNDER`=2, `FLAG_RXSTALL`=3;
  - join-mode encoding (`JOIN_NONE`, `JOIN_TX`, `JOIN_RX`).
- **Sub-module `pio_fifo_buf`**, instantiated twice (TX, RX):
  - holds 2*DEPTH x WIDTH storage, read/write pointers and level;
  - inputs: `cap` (0 / DEPTH / 2*DEPTH), `flush`, `wr`, `wdata`, `rd`;
  - outputs: `rdata`, `empty`, `full`, `level`.
- **Top level:** join decode, flush generation, strobe qualification and flag logic.

## Test plan
- **Basic TX/RX:** host writes 0xA1, 0xB2, 0xC3, 0xD4 → `host_tx_full`=1, `tx_level`=4. Then 4 machine pulls return the same order; `mach_empty`=1 after the last. Repeat for RX.
- **Overflow/underflow:** fifth host write when TX holds 4 → txover set, data dropped, level stays 4. `flag_clr`=4'b0010 → flag clears. The same cycle as a new overflow → flag stays set.
- **Blocking pull:** `mach_pull` on empty TX for 3 cycles → txstall set, `mach_din`=0. Host writes 0x55 → next cycle `mach_empty`=0, `mach_din`=0x55. Pull → level 0.
- **Simultaneous events:** TX level 2 with write+pull in the same cycle → level 2, head advances. Empty TX with write+pull → level 1, txstall set.
- **Join:** `join_tx`=1 → 8 host writes accepted, 9th sets txover, `mach_full`=1 and `host_rx_empty`=1. Deasserting `join_tx` flushes: `tx_level`=0 next cycle, flags unchanged.
- **Reset mid-stream:** reset with TX level 3 and RX level 2 → both levels 0, empties 1, flags 0, data outputs 0.
